// File: rtl/dmac_cmd_issuer.sv
// rtl/dmac_cmd_issuer.sv - buffers DMA descriptors and programs mchan over the peripheral bus
module dmac_cmd_issuer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned PE_ID_WIDTH = 5,
    parameter int unsigned MY_ID       = 0,
    parameter logic [ADDR_WIDTH-1:0] CMD_ADDR = 32'h1020_4400,
    parameter int unsigned TID_WIDTH   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    desc_valid_i,
    output logic                    desc_ready_o,
    input  logic [DATA_WIDTH-1:0]   desc_cmd_i,
    input  logic [DATA_WIDTH-1:0]   desc_tcdm_addr_i,
    input  logic [DATA_WIDTH-1:0]   desc_ext_addr_i,
    output logic                    tid_valid_o,
    input  logic                    tid_ready_i,
    output logic [TID_WIDTH-1:0]    tid_o,
    output logic                    tid_err_o,
    output logic                    per_req_o,
    output logic [ADDR_WIDTH-1:0]   per_add_o,
    output logic                    per_wen_o,
    output logic [DATA_WIDTH-1:0]   per_wdata_o,
    output logic [DATA_WIDTH/8-1:0] per_be_o,
    output logic [PE_ID_WIDTH-1:0]  per_id_o,
    input  logic                    per_gnt_i,
    input  logic                    per_r_valid_i,
    input  logic [DATA_WIDTH-1:0]   per_r_rdata_i,
    input  logic                    per_r_opc_i,
    input  logic [PE_ID_WIDTH-1:0]  per_r_id_i,
    output logic                    busy_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        OUT  = 2'd3
    } state_t;

    logic [DATA_WIDTH-1:0] cmd_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] tcdm_mem [DEPTH];
    logic [DATA_WIDTH-1:0] ext_mem  [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    state_t               state_q, state_d;
    logic [1:0]           phase_q, phase_d;
    logic                 err_q, err_d;
    logic [TID_WIDTH-1:0] tid_q, tid_d;

    logic push, pop, full, rsp_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // No bypass: a full FIFO refuses a push even when the head pops this cycle.
    assign full         = (count_q == CNT_W'(DEPTH));
    assign desc_ready_o = !full;
    assign push         = desc_valid_i && !full;
    assign rsp_ok       = per_r_valid_i && (per_r_id_i == PE_ID_WIDTH'(MY_ID));

    assign wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    assign rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    assign per_add_o   = CMD_ADDR;
    assign per_be_o    = '1;
    assign per_id_o    = PE_ID_WIDTH'(MY_ID);
    assign tid_o       = tid_q;
    assign tid_err_o   = err_q;
    assign busy_o      = (count_q != '0) || (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (push) begin
            cmd_mem[wr_ptr_q]  <= desc_cmd_i;
            tcdm_mem[wr_ptr_q] <= desc_tcdm_addr_i;
            ext_mem[wr_ptr_q]  <= desc_ext_addr_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            phase_q  <= '0;
            err_q    <= 1'b0;
            tid_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            phase_q  <= phase_d;
            err_q    <= err_d;
            tid_q    <= tid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        err_d       = err_q;
        tid_d       = tid_q;
        per_req_o   = 1'b0;
        per_wen_o   = 1'b1;
        per_wdata_o = '0;
        tid_valid_o = 1'b0;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = REQ;
                    phase_d = 2'd0;
                    err_d   = 1'b0;
                end
            end
            REQ: begin
                // Phase 0 reads the transfer ID; phases 1-3 write cmd, TCDM and ext address.
                per_req_o = 1'b1;
                per_wen_o = (phase_q == 2'd0);
                case (phase_q)
                    2'd1:    per_wdata_o = cmd_mem[rd_ptr_q];
                    2'd2:    per_wdata_o = tcdm_mem[rd_ptr_q];
                    2'd3:    per_wdata_o = ext_mem[rd_ptr_q];
                    default: per_wdata_o = '0;
                endcase
                if (per_gnt_i) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_ok) begin
                    err_d = err_q | per_r_opc_i;
                    if (phase_q == 2'd0) begin
                        tid_d = per_r_rdata_i[TID_WIDTH-1:0];
                    end
                    if (phase_q != 2'd3) begin
                        phase_d = phase_q + 2'd1;
                        state_d = REQ;
                    end else begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                tid_valid_o = 1'b1;
                if (tid_ready_i) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmac_cmd_issuer.sv
// tb/tb_dmac_cmd_issuer.sv - directed bench for dmac_cmd_issuer
module tb_dmac_cmd_issuer;

    localparam logic [31:0] CMD_ADDR = 32'h1020_4400;

    logic        clk;
    logic        rst;
    logic        desc_valid;
    logic        desc_ready;
    logic [31:0] desc_cmd, desc_tcdm, desc_ext;
    logic        tid_valid, tid_ready;
    logic [3:0]  tid;
    logic        tid_err;
    logic        per_req;
    logic [31:0] per_add;
    logic        per_wen;
    logic [31:0] per_wdata;
    logic [3:0]  per_be;
    logic [4:0]  per_id;
    logic        per_gnt, per_r_valid;
    logic [31:0] per_r_rdata;
    logic        per_r_opc;
    logic [4:0]  per_r_id;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int e0, t_done;

    logic [31:0] dc [5];
    logic [31:0] dt [5];
    logic [31:0] de [5];
    logic [3:0]  dtid [5];

    dmac_cmd_issuer dut (
        .clk_i(clk), .rst_i(rst),
        .desc_valid_i(desc_valid), .desc_ready_o(desc_ready),
        .desc_cmd_i(desc_cmd), .desc_tcdm_addr_i(desc_tcdm), .desc_ext_addr_i(desc_ext),
        .tid_valid_o(tid_valid), .tid_ready_i(tid_ready), .tid_o(tid), .tid_err_o(tid_err),
        .per_req_o(per_req), .per_add_o(per_add), .per_wen_o(per_wen),
        .per_wdata_o(per_wdata), .per_be_o(per_be), .per_id_o(per_id),
        .per_gnt_i(per_gnt), .per_r_valid_i(per_r_valid), .per_r_rdata_i(per_r_rdata),
        .per_r_opc_i(per_r_opc), .per_r_id_i(per_r_id), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_desc_ready"}, 32'(desc_ready), 32'd1);
        chk({tag, "_tid_valid"}, 32'(tid_valid), 32'd0);
        chk({tag, "_tid"}, 32'(tid), 32'd0);
        chk({tag, "_tid_err"}, 32'(tid_err), 32'd0);
        chk({tag, "_per_req"}, 32'(per_req), 32'd0);
        chk({tag, "_per_wen"}, 32'(per_wen), 32'd1);
        chk({tag, "_per_wdata"}, per_wdata, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_per_add"}, per_add, CMD_ADDR);
        chk({tag, "_per_be"}, 32'(per_be), 32'hF);
        chk({tag, "_per_id"}, 32'(per_id), 32'd0);
    endtask

    // Plays the bus slave for one access: waits for req, checks it, grants and responds.
    task automatic bus_access(input logic ew, input logic [31:0] ewd, input int gd, input int rd,
                              input logic [31:0] rdata, input logic opc, input logic bad);
        int n = 0;
        while (!per_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 32'(per_req), 32'd1);
        chk("no_tid_during_bus", 32'(tid_valid), 32'd0);
        chk("req_add", per_add, CMD_ADDR);
        for (int i = 0; i <= gd; i++) begin
            chk("req_held", 32'(per_req), 32'd1);
            chk("req_wen", 32'(per_wen), 32'(ew));
            chk("req_wdata", per_wdata, ewd);
            if (i < gd) @(negedge clk);
        end
        per_gnt = 1'b1;
        @(negedge clk);
        per_gnt = 1'b0;
        for (int i = 0; i < rd; i++) begin
            chk("no_req_before_rsp", 32'(per_req), 32'd0);
            @(negedge clk);
        end
        if (bad) begin
            per_r_valid = 1'b1;
            per_r_id    = 5'd3;
            per_r_rdata = 32'h5A5A_5A5A;
            per_r_opc   = 1'b1;
            @(negedge clk);
            per_r_valid = 1'b0;
            per_r_opc   = 1'b0;
            per_r_id    = 5'd0;
            repeat (2) begin
                chk("bad_id_ignored", 32'(per_req), 32'd0);
                @(negedge clk);
            end
        end
        chk("no_req_at_rsp", 32'(per_req), 32'd0);
        per_r_valid = 1'b1;
        per_r_id    = 5'd0;
        per_r_rdata = rdata;
        per_r_opc   = opc;
        @(negedge clk);
        per_r_valid = 1'b0;
        per_r_opc   = 1'b0;
        per_r_rdata = 32'h0;
    endtask

    task automatic run_desc(input int k, input int opc_ph, input int bad_ph, input logic rnd);
        logic [31:0] wd;
        int gd, rd;
        for (int ph = 0; ph < 4; ph++) begin
            wd = (ph == 0) ? 32'h0 : (ph == 1) ? dc[k] : (ph == 2) ? dt[k] : de[k];
            gd = rnd ? int'($urandom_range(0, 7)) : 0;
            rd = rnd ? int'($urandom_range(0, 5)) : 0;
            bus_access(ph == 0, wd, gd, rd,
                       (ph == 0) ? {28'hABCD_000, dtid[k]} : 32'hDEAD_BEE0,
                       ph == opc_ph, ph == bad_ph);
        end
        t_done = cyc;
        chk("tid_valid", 32'(tid_valid), 32'd1);
        chk("tid_value", 32'(tid), 32'(dtid[k]));
        chk("tid_err", 32'(tid_err), 32'(opc_ph < 4));
        @(negedge clk);
        chk("tid_valid_held", 32'(tid_valid), 32'd1);
        chk("tid_value_held", 32'(tid), 32'(dtid[k]));
    endtask

    task automatic pop(input logic more);
        tid_ready = 1'b1;
        @(negedge clk);
        tid_ready = 1'b0;
        chk("pop_tid_valid_low", 32'(tid_valid), 32'd0);
        chk("pop_idle_no_req", 32'(per_req), 32'd0);
        @(negedge clk);
        chk("pop_next_req", 32'(per_req), 32'(more));
        chk("pop_busy", 32'(busy), 32'(more));
    endtask

    initial begin
        dc[0] = 32'h0004_0100; dt[0] = 32'h1000_0200; de[0] = 32'h1C00_8000; dtid[0] = 4'h5;
        dc[1] = 32'h0002_0040; dt[1] = 32'h1000_1000; de[1] = 32'h1C01_0000; dtid[1] = 4'h2;
        dc[2] = 32'h0006_0800; dt[2] = 32'h1000_2000; de[2] = 32'h1C02_0000; dtid[2] = 4'h9;
        dc[3] = 32'h0001_0004; dt[3] = 32'h1000_3000; de[3] = 32'h1C03_0000; dtid[3] = 4'h3;
        dc[4] = 32'h0007_FFFC; dt[4] = 32'h1000_4000; de[4] = 32'h1C04_0000; dtid[4] = 4'hC;

        rst = 1'b1; desc_valid = 1'b0; tid_ready = 1'b0;
        desc_cmd = '0; desc_tcdm = '0; desc_ext = '0;
        per_gnt = 1'b0; per_r_valid = 1'b0; per_r_rdata = '0; per_r_opc = 1'b0; per_r_id = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_held");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_released");

        // Single descriptor, zero-wait bus, exact latency.
        desc_valid = 1'b1;
        desc_cmd = dc[0]; desc_tcdm = dt[0]; desc_ext = de[0];
        @(negedge clk);
        e0 = cyc;
        desc_valid = 1'b0;
        chk("single_busy_after_e0", 32'(busy), 32'd1);
        chk("single_no_req_after_e0", 32'(per_req), 32'd0);
        @(negedge clk);
        chk("single_req_after_e1", 32'(per_req), 32'd1);
        run_desc(0, 4, 4, 1'b0);
        chk("single_tid_latency", 32'(t_done - e0), 32'd9);
        pop(1'b0);
        chk("single_ready_after", 32'(desc_ready), 32'd1);

        // Fill to DEPTH with tid_ready low; the fifth is held off until the first pop.
        for (int k = 0; k < 4; k++) begin
            desc_valid = 1'b1;
            desc_cmd = dc[k]; desc_tcdm = dt[k]; desc_ext = de[k];
            chk("fill_ready", 32'(desc_ready), 32'd1);
            @(negedge clk);
        end
        desc_cmd = dc[4]; desc_tcdm = dt[4]; desc_ext = de[4];
        chk("full_not_ready", 32'(desc_ready), 32'd0);
        @(negedge clk);
        chk("full_not_ready2", 32'(desc_ready), 32'd0);
        run_desc(0, 4, 4, 1'b1);
        chk("full_before_pop", 32'(desc_ready), 32'd0);
        tid_ready = 1'b1;
        @(negedge clk);
        tid_ready = 1'b0;
        chk("pop_frees_slot", 32'(desc_ready), 32'd1);
        chk("pop_idle_cycle", 32'(per_req), 32'd0);
        @(negedge clk);
        desc_valid = 1'b0;
        chk("fifth_accepted_full", 32'(desc_ready), 32'd0);
        chk("backtoback_req", 32'(per_req), 32'd1);

        run_desc(1, 4, 1, 1'b1);
        pop(1'b1);
        run_desc(2, 2, 4, 1'b1);
        pop(1'b1);
        run_desc(3, 4, 4, 1'b1);
        pop(1'b1);
        run_desc(4, 4, 4, 1'b1);
        pop(1'b0);

        // Reset while waiting for the phase-2 response with three entries queued.
        for (int k = 0; k < 3; k++) begin
            desc_valid = 1'b1;
            desc_cmd = dc[k]; desc_tcdm = dt[k]; desc_ext = de[k];
            @(negedge clk);
        end
        desc_valid = 1'b0;
        bus_access(1'b1, 32'h0, 0, 0, 32'h0000_0006, 1'b0, 1'b0);
        bus_access(1'b0, dc[0], 1, 1, 32'h0, 1'b0, 1'b0);
        for (int n = 0; n < 50 && !per_req; n++) @(negedge clk);
        chk("ph2_req", 32'(per_req), 32'd1);
        chk("ph2_wdata", per_wdata, dt[0]);
        per_gnt = 1'b1;
        @(negedge clk);
        per_gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_req", 32'(per_req), 32'd0);
            chk("post_rst_idle", 32'(busy), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
